// File: rtl/shift_add_multiplier_if.sv
// Request/response bundle for shift_add_multiplier.
// The signed_in wire exists only when SHIFT_ADD_SIGNED_EN is defined.
interface shift_add_multiplier_if #(parameter int WIDTH = 4);
    logic                   start;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
`ifdef SHIFT_ADD_SIGNED_EN
    logic                   signed_in;
`endif
    logic                   ready;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output x,
        output y,
`ifdef SHIFT_ADD_SIGNED_EN
        output signed_in,
`endif
        input  ready,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  x,
        input  y,
`ifdef SHIFT_ADD_SIGNED_EN
        input  signed_in,
`endif
        output ready,
        output done,
        output product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One add or shift micro-step per clock; latency is WIDTH + popcount(y)
// micro-steps followed by a single DONE cycle.
// Optional feature macro: SHIFT_ADD_SIGNED_EN adds two's-complement mode
// (sign-extended adds, arithmetic shift, subtract on the final iteration).
//
// state | meaning
// IDLE  | waiting for start, ready=1
// ADD   | accumulate multiplicand into A
// SHIFT | shift {A,Q} right one bit, advance iteration count
// DONE  | product valid, one-cycle done pulse
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     m_reg;
    logic [WIDTH:0]       a_reg;
    logic [WIDTH-1:0]     q_reg;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   product_reg;

    logic                 last;
    logic                 fill;
    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       a_sum;
    logic [2*WIDTH:0]     shifted;

    assign last = (cnt == LAST);

`ifdef SHIFT_ADD_SIGNED_EN
    logic sgn;
    // Signed mode: the multiplier's MSB carries weight -2^(WIDTH-1), so the
    // final iteration subtracts instead of adding.
    assign m_ext = sgn ? {m_reg[WIDTH-1], m_reg} : {1'b0, m_reg};
    assign a_sum = (sgn && last) ? (a_reg - m_ext) : (a_reg + m_ext);
    assign fill  = sgn & a_reg[WIDTH];
`else
    assign m_ext = {1'b0, m_reg};
    assign a_sum = a_reg + m_ext;
    assign fill  = 1'b0;
`endif

    assign shifted = {fill, a_reg, q_reg[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode; the next step depends on the bit that will be in Q[0].
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = bus.y[0] ? ADD : SHIFT;
            ADD:     state_nxt = SHIFT;
            SHIFT:   if (last)          state_nxt = DONE;
                     else if (q_reg[1]) state_nxt = ADD;
                     else               state_nxt = SHIFT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, accumulate, shift, and product load on DONE entry.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_reg       <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            cnt         <= '0;
            product_reg <= '0;
`ifdef SHIFT_ADD_SIGNED_EN
            sgn         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_reg <= bus.x;
                        q_reg <= bus.y;
                        a_reg <= '0;
                        cnt   <= '0;
`ifdef SHIFT_ADD_SIGNED_EN
                        sgn   <= bus.signed_in;
`endif
                    end
                end
                ADD: begin
                    a_reg <= a_sum;
                end
                SHIFT: begin
                    {a_reg, q_reg} <= shifted;
                    cnt            <= cnt + 1'b1;
                    if (last) product_reg <= shifted[2*WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.ready   = (state == IDLE);
    assign bus.done    = (state == DONE);
    assign bus.product = product_reg;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: a WIDTH=4 and a WIDTH=8 instance share clock
// and reset. A reference model predicts acceptance, latency and product and
// queues expectations; a monitor pops them on each done pulse.
module tb_shift_add_multiplier;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    always #5 clk_in = ~clk_in;

    shift_add_multiplier_if #(.WIDTH(4)) bi4 ();
    shift_add_multiplier_if #(.WIDTH(8)) bi8 ();

    shift_add_multiplier #(.WIDTH(4)) u4 (.clk_in(clk_in), .rst_in(rst_in), .bus(bi4));
    shift_add_multiplier #(.WIDTH(8)) u8 (.clk_in(clk_in), .rst_in(rst_in), .bus(bi8));

    typedef struct {
        logic [15:0] p;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int wof(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic logic [15:0] model_prod(input int w, input logic [15:0] a,
                                               input logic [15:0] b, input logic s);
        longint sa, sb, r;
        sa = longint'(a);
        sb = longint'(b);
        if (s) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        r = sa * sb;
        r = r & ((longint'(1) << (2 * w)) - 1);
        return r[15:0];
    endfunction

    logic        st [2];
    logic        rd [2];
    logic        dn [2];
    logic        sg [2];
    logic [15:0] xv [2];
    logic [15:0] yv [2];
    logic [15:0] pr [2];

    always_comb begin
        st[0] = bi4.start;  st[1] = bi8.start;
        rd[0] = bi4.ready;  rd[1] = bi8.ready;
        dn[0] = bi4.done;   dn[1] = bi8.done;
        xv[0] = 16'(bi4.x); xv[1] = 16'(bi8.x);
        yv[0] = 16'(bi4.y); yv[1] = 16'(bi8.y);
        pr[0] = 16'(bi4.product);
        pr[1] = 16'(bi8.product);
`ifdef SHIFT_ADD_SIGNED_EN
        sg[0] = bi4.signed_in;
        sg[1] = bi8.signed_in;
`else
        sg[0] = 1'b0;
        sg[1] = 1'b0;
`endif
    end

    int busy [2] = '{0, 0};
    int age  [2] = '{0, 0};
    int acc  [2] = '{0, 0};
    int dcnt [2] = '{0, 0};

    // Reference model: predicts which starts are taken and what they produce.
    always @(posedge clk_in or negedge rst_in) begin
        exp_t e;
        int   pc;
        if (!rst_in) begin
            for (int i = 0; i < 2; i++) begin
                busy[i] = 0;
                age[i]  = 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                age[i]++;
                if (busy[i] > 0) begin
                    busy[i]--;
                end else if (st[i]) begin
                    pc      = $countones(yv[i]);
                    e.p     = model_prod(wof(i), xv[i], yv[i], sg[i]);
                    e.lat   = wof(i) + pc + 1;
                    busy[i] = wof(i) + pc + 1;
                    age[i]  = 0;
                    acc[i]++;
                    if (i == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
        end
    end

    // Monitor: ready against the model, done pulses against the queue.
    always @(negedge clk_in) begin
        exp_t  e;
        string tg;
        if (rst_in) begin
            for (int i = 0; i < 2; i++) begin
                tg = (i == 0) ? "w4" : "w8";
                check({"ready_", tg}, 32'(rd[i]), 32'(busy[i] == 0));
                if (dn[i]) begin
                    dcnt[i]++;
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        check({"spurious_done_", tg}, 32'd1, 32'd0);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        check({"product_", tg}, 32'(pr[i]), 32'(e.p));
                        check({"done_cycle_", tg}, 32'(age[i] + 1), 32'(e.lat));
                    end
                end
            end
        end
    end

    task automatic go(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
        if (i == 0) begin
            bi4.x = a[3:0];
            bi4.y = b[3:0];
            bi4.start = 1'b1;
`ifdef SHIFT_ADD_SIGNED_EN
            bi4.signed_in = s;
`endif
        end else begin
            bi8.x = a[7:0];
            bi8.y = b[7:0];
            bi8.start = 1'b1;
`ifdef SHIFT_ADD_SIGNED_EN
            bi8.signed_in = s;
`endif
        end
        @(negedge clk_in);
        bi4.start = 1'b0;
        bi8.start = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int limit);
        int n;
        n = 0;
        while (((i == 0) ? q0.size() : q1.size()) != 0 || busy[i] != 0) begin
            @(negedge clk_in);
            n++;
            if (n > limit) begin
                check("wait_idle_timeout", 32'(n), 32'(limit));
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        bi4.start = 1'b0; bi4.x = '0; bi4.y = '0;
        bi8.start = 1'b0; bi8.x = '0; bi8.y = '0;
`ifdef SHIFT_ADD_SIGNED_EN
        bi4.signed_in = 1'b0;
        bi8.signed_in = 1'b0;
`endif
        repeat (3) @(negedge clk_in);
        check("reset_ready_w4", 32'(rd[0]), 32'd1);
        check("reset_done_w4", 32'(dn[0]), 32'd0);
        check("reset_product_w4", 32'(pr[0]), 32'd0);
        check("reset_ready_w8", 32'(rd[1]), 32'd1);
        check("reset_done_w8", 32'(dn[1]), 32'd0);
        check("reset_product_w8", 32'(pr[1]), 32'd0);
        #2 rst_in = 1'b1;
        @(negedge clk_in);

        // 3 * 5, single-cycle start.
        go(0, 16'd3, 16'd5, 1'b0);
        check("t1_ready_low", 32'(rd[0]), 32'd0);
        wait_idle(0, 40);
        check("t1_product", 32'(pr[0]), 32'd15);

        // 15 * 0 then 15 * 15, second start the cycle after the first done.
        go(0, 16'd15, 16'd0, 1'b0);
        n = 0;
        while (!dn[0] && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 50) check("t2_done_timeout", 32'(n), 32'd50);
        check("t2_product_a", 32'(pr[0]), 32'd0);
        @(negedge clk_in);
        go(0, 16'd15, 16'd15, 1'b0);
        wait_idle(0, 40);
        check("t2_product_b", 32'(pr[0]), 32'd225);

        // WIDTH=8, start held high with operands changing every cycle.
        bi8.start = 1'b1;
        n = 0;
        while (acc[1] < 1000 && n < 20000) begin
            bi8.x = 8'($urandom);
            case (n % 53)
                0:       bi8.y = 8'hFF;
                1:       bi8.y = 8'h00;
                default: bi8.y = 8'($urandom);
            endcase
            @(negedge clk_in);
            n++;
        end
        bi8.start = 1'b0;
        if (n >= 20000) check("t3_timeout", 32'(n), 32'd20000);
        wait_idle(1, 40);
        check("t3_accepts", 32'(acc[1]), 32'd1000);
        check("t3_one_done_per_start", 32'(dcnt[1]), 32'(acc[1]));

        // Reset in the middle of 7 * 9 aborts it.
        d0 = dcnt[0];
        go(0, 16'd7, 16'd9, 1'b0);
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        check("t4_rst_product", 32'(pr[0]), 32'd0);
        check("t4_rst_ready", 32'(rd[0]), 32'd1);
        check("t4_rst_done", 32'(dn[0]), 32'd0);
        @(negedge clk_in);
        #2 rst_in = 1'b1;
        repeat (20) @(negedge clk_in);
        check("t4_no_done", 32'(dcnt[0]), 32'(d0));
        go(0, 16'd2, 16'd3, 1'b0);
        wait_idle(0, 40);
        check("t4_product", 32'(pr[0]), 32'd6);

        // 6 * 7 with operands and start toggling while busy.
        d0 = dcnt[0];
        go(0, 16'd6, 16'd7, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bi4.x = 4'($urandom);
            bi4.y = 4'($urandom);
            bi4.start = (k % 2 == 0);
            @(negedge clk_in);
        end
        bi4.start = 1'b0;
        wait_idle(0, 40);
        check("t5_product", 32'(pr[0]), 32'd42);
        check("t5_single_done", 32'(dcnt[0]), 32'(d0 + 1));

`ifdef SHIFT_ADD_SIGNED_EN
        go(0, 16'hD, 16'h5, 1'b1);
        wait_idle(0, 40);
        check("sgn_m3x5", 32'(pr[0]), 32'hF1);
        go(0, 16'h7, 16'h8, 1'b1);
        wait_idle(0, 40);
        check("sgn_7xm8", 32'(pr[0]), 32'hC8);
        go(0, 16'h8, 16'h8, 1'b1);
        wait_idle(0, 40);
        check("sgn_m8xm8", 32'(pr[0]), 32'h40);
        go(0, 16'hD, 16'h5, 1'b0);
        wait_idle(0, 40);
        check("uns_13x5", 32'(pr[0]), 32'd65);
`endif

        repeat (3) @(negedge clk_in);
        check("final_queue_w4", 32'(q0.size()), 32'd0);
        check("final_queue_w8", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
